flash_port_arbiter: RTL and testbench

- Shares the single read-only flash port between NumReq OBI managers, e.g. core fetch and a boot-copy engine. On ASIC the flash port is the QSPI XIP controller behind the OBI-to-AHB adapter; on FPGA it is the ROM shim.
- Round-robin arbitration with at most one outstanding downstream transaction.
- Writes and out-of-window addresses receive a local error response and are never forwarded.
- A response-timeout watchdog protects requesters from a hung flash; any late flash response is drained and dropped.

---
 rtl/flash_port_arbiter.sv | 130 +++++++++++++
 tb/tb_flash_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: round-robin share of the read-only flash port among OBI managers, with local errors and a response timeout.
module flash_port_arbiter #(
  parameter int NumReq = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int IdWidth = 1,
  parameter logic [AddrWidth-1:0] FlashBase = 32'h4000_0000,
  parameter logic [AddrWidth-1:0] FlashSize = 32'h0100_0000,
  parameter int TimeoutCycles = 1024,
  parameter logic [DataWidth-1:0] ErrData = 32'hBADCAB1E
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             up_req_i,
  input  logic [NumReq-1:0]             up_we_i,
  input  logic [NumReq*AddrWidth-1:0]   up_addr_i,
  input  logic [NumReq*IdWidth-1:0]     up_aid_i,
  output logic [NumReq-1:0]             up_gnt_o,
  output logic [NumReq-1:0]             up_rvalid_o,
  output logic [DataWidth-1:0]          up_rdata_o,
  output logic                          up_err_o,
  output logic [IdWidth-1:0]            up_rid_o,
  output logic                          dn_req_o,
  output logic [AddrWidth-1:0]          dn_addr_o,
  input  logic                          dn_gnt_i,
  input  logic                          dn_rvalid_i,
  input  logic [DataWidth-1:0]          dn_rdata_i,
  input  logic                          dn_err_i,
  output logic                          busy_o,
  output logic                          timeout_o
);
  localparam int PW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CW = $clog2(TimeoutCycles);
  localparam logic [AddrWidth:0] WinLo = {1'b0, FlashBase};
  localparam logic [AddrWidth:0] WinHi = {1'b0, FlashBase} + {1'b0, FlashSize};
  typedef enum logic [1:0] {IDLE, ERR_RSP, WAIT_RSP, DRAIN} state_e;
  state_e state;
  logic [PW-1:0] rr_ptr, sel_q, arb_sel, sel, nxt_ptr, idx;
  logic lock, any_req, req_ok, bad, tmo;
  logic [IdWidth-1:0] aid_q, sel_aid;
  logic [CW-1:0] cnt;
  logic [AddrWidth-1:0] sel_addr;
  // Scan downward so the last hit, i.e. the first port at or after rr_ptr, wins.
  always_comb begin
    arb_sel = '0;
    any_req = 1'b0;
    idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NumReq);
      if (up_req_i[idx]) begin
        arb_sel = idx;
        any_req = 1'b1;
      end
    end
  end
  assign sel = lock ? sel_q : arb_sel;
  assign req_ok = lock | any_req;
  assign sel_addr = up_addr_i[sel*AddrWidth +: AddrWidth];
  assign sel_aid = up_aid_i[sel*IdWidth +: IdWidth];
  assign bad = up_we_i[sel] | ({1'b0, sel_addr} < WinLo) | ({1'b0, sel_addr} >= WinHi);
  assign nxt_ptr = (sel == PW'(NumReq - 1)) ? '0 : sel + 1'b1;
  assign tmo = cnt == CW'(TimeoutCycles - 1);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      rr_ptr <= '0;
      lock <= 1'b0;
      cnt <= '0;
      sel_q <= '0;
      aid_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_ok) begin
          sel_q <= sel;
          if (bad || dn_gnt_i) begin
            aid_q <= sel_aid;
            lock <= 1'b0;
            cnt <= '0;
            rr_ptr <= nxt_ptr;
            state <= bad ? ERR_RSP : WAIT_RSP;
          end else begin
            lock <= 1'b1;
          end
        end
        ERR_RSP: state <= IDLE;
        WAIT_RSP: begin
          cnt <= cnt + 1'b1;
          if (dn_rvalid_i) state <= IDLE;
          else if (tmo) state <= DRAIN;
        end
        DRAIN: if (dn_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    up_gnt_o = '0;
    up_rvalid_o = '0;
    up_rdata_o = '0;
    up_err_o = 1'b0;
    up_rid_o = '0;
    dn_req_o = 1'b0;
    dn_addr_o = '0;
    timeout_o = 1'b0;
    if (rst_ni) begin
      case (state)
        IDLE: if (req_ok) begin
          dn_req_o = !bad;
          dn_addr_o = bad ? '0 : sel_addr;
          up_gnt_o[sel] = bad | dn_gnt_i;
        end
        ERR_RSP: begin
          up_rvalid_o[sel_q] = 1'b1;
          up_err_o = 1'b1;
          up_rdata_o = ErrData;
          up_rid_o = aid_q;
        end
        WAIT_RSP: if (dn_rvalid_i || tmo) begin
          up_rvalid_o[sel_q] = 1'b1;
          up_err_o = dn_rvalid_i ? dn_err_i : 1'b1;
          up_rdata_o = dn_rvalid_i ? dn_rdata_i : ErrData;
          up_rid_o = aid_q;
          timeout_o = !dn_rvalid_i;
        end
        default: ;
      endcase
    end
  end
  assign busy_o = rst_ni & ((state != IDLE) | dn_req_o);
endmodule

// File: tb/tb_flash_port_arbiter.sv
// tb_flash_port_arbiter: scoreboard bench with per-port drivers and a latency-configurable flash model.
module tb_flash_port_arbiter;
  localparam logic [31:0] FB = 32'h4000_0000;
  localparam logic [31:0] FS = 32'h0100_0000;
  localparam logic [31:0] ERR = 32'hBADCAB1E;
  localparam logic [31:0] K = 32'h5234_5668;
  typedef struct { logic we; logic [31:0] addr; logic aid; bit tmo; } job_t;
  typedef struct { logic [31:0] rdata; logic err; logic rid; } exp_t;
  logic clk = 0, rst_ni = 0;
  logic [1:0] up_req, up_we, up_aid, up_gnt, up_rvalid;
  logic [31:0] addr_a [2];
  logic [63:0] up_addr;
  logic [31:0] up_rdata, dn_addr, dn_rdata, fl_addr;
  logic up_err, up_rid, dn_req, dn_gnt, dn_rvalid, dn_err, busy, tmo_o;
  bit run = 1, gnt_en = 1, mute = 0, fl_busy;
  int rsp_lat = 1, fl_wait, late_req = 0, late_done;
  int n_tests = 0, n_fail = 0, cyc = 0, tmo_cnt = 0, rv_total = 0, gnt_cyc = 0, rv_cyc = 0;
  int gnt_cyc_p [2], rv_cyc_p [2];
  logic [31:0] last_rdata;
  logic last_err;
  job_t jobs [2][$];
  exp_t exp_q [2][$];
  logic [1:0] gnt_log [$];
  logic dnreq_log [$];
  assign up_addr = {addr_a[1], addr_a[0]};
  assign dn_gnt = dn_req & gnt_en;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  flash_port_arbiter #(.NumReq(2), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .up_req_i(up_req), .up_we_i(up_we), .up_addr_i(up_addr),
    .up_aid_i(up_aid), .up_gnt_o(up_gnt), .up_rvalid_o(up_rvalid), .up_rdata_o(up_rdata),
    .up_err_o(up_err), .up_rid_o(up_rid), .dn_req_o(dn_req), .dn_addr_o(dn_addr),
    .dn_gnt_i(dn_gnt), .dn_rvalid_i(dn_rvalid), .dn_rdata_i(dn_rdata), .dn_err_i(dn_err),
    .busy_o(busy), .timeout_o(tmo_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic exp_t mk_exp(job_t j);
    exp_t e;
    bit bad;
    bad = j.we || (j.addr < FB) || ({1'b0, j.addr} >= {1'b0, FB} + {1'b0, FS});
    e.rdata = (bad || j.tmo) ? ERR : j.addr ^ K;
    e.err = bad || j.tmo;
    e.rid = j.aid;
    return e;
  endfunction
  function automatic logic [1:0] log_at(int i);
    return (i < gnt_log.size()) ? gnt_log[i] : 2'bxx;
  endfunction
  function automatic logic dn_at(int i);
    return (i < dnreq_log.size()) ? dnreq_log[i] : 1'bx;
  endfunction
  task automatic push_job(input int p, input logic we, input logic [31:0] a, input logic aid, input bit t = 0);
    job_t j;
    j.we = we; j.addr = a; j.aid = aid; j.tmo = t;
    jobs[p].push_back(j);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 2000 && (jobs[0].size() > 0 || jobs[1].size() > 0 || exp_q[0].size() > 0 ||
               exp_q[1].size() > 0 || busy || up_req != 0));
    check("idle_reached", n < 2000, 1);
  endtask
  // Requester drivers: one job per port at a time, request held until granted.
  initial begin
    bit active [2];
    int wt [2];
    job_t j;
    up_req = 0; up_we = 0; up_aid = 0; addr_a[0] = 0; addr_a[1] = 0;
    active[0] = 0; active[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (active[p]) begin
          wt[p]++;
          if (wt[p] > 300) begin
            check("gnt_wait", up_gnt[p], 1);
            active[p] = 0;
          end
        end else if (run && jobs[p].size() > 0) begin
          j = jobs[p].pop_front();
          up_req[p] = 1; up_we[p] = j.we; addr_a[p] = j.addr; up_aid[p] = j.aid;
          exp_q[p].push_back(mk_exp(j));
          active[p] = 1;
          wt[p] = 0;
        end else begin
          up_req[p] = 0; up_we[p] = 0;
        end
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (active[p] && up_gnt[p]) active[p] = 0;
    end
  end
  // Flash model: answers rsp_lat cycles after the handshake cycle unless muted.
  initial begin
    dn_rvalid = 0; dn_rdata = 0; dn_err = 0; fl_busy = 0; fl_wait = 0; late_done = 0; fl_addr = 0;
    forever begin
      @(posedge clk); #1;
      dn_rvalid = 0; dn_rdata = 0;
      if (late_req != late_done) begin
        late_done++;
        dn_rvalid = 1; dn_rdata = 32'hDEAD_BEEF; fl_busy = 0;
      end else if (fl_busy) begin
        fl_wait--;
        if (fl_wait <= 0 && !mute) begin
          dn_rvalid = 1; dn_rdata = fl_addr ^ K; fl_busy = 0;
        end
      end
      @(negedge clk);
      if (!rst_ni) fl_busy = 0;
      else if (dn_req && dn_gnt) begin
        fl_busy = 1; fl_wait = rsp_lat; fl_addr = dn_addr;
      end
    end
  end
  // Monitor and scoreboard.
  always @(negedge clk) begin
    int p;
    exp_t e;
    if (rst_ni) begin
      if (tmo_o) tmo_cnt++;
      if (up_gnt != 0) begin
        gnt_log.push_back(up_gnt);
        dnreq_log.push_back(dn_req);
        gnt_cyc = cyc;
        gnt_cyc_p[int'(up_gnt[1])] = cyc;
        check("gnt_onehot", $onehot(up_gnt), 1);
        check("gnt_during_rv", up_rvalid, 0);
      end
      if (up_rvalid != 0) begin
        p = int'(up_rvalid[1]);
        rv_cyc = cyc; rv_cyc_p[p] = cyc; rv_total++;
        last_rdata = up_rdata; last_err = up_err;
        check("rv_onehot", $onehot(up_rvalid), 1);
        if (exp_q[p].size() == 0) check("rv_unexpected", up_rvalid, 0);
        else begin
          e = exp_q[p].pop_front();
          check("rv_rdata", up_rdata, e.rdata);
          check("rv_err", up_err, e.err);
          check("rv_rid", up_rid, e.rid);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int g0, g1, rv0, rv1, n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", up_gnt, 0);
    check("rst_rvalid", up_rvalid, 0);
    check("rst_rdata", up_rdata, 0);
    check("rst_dnreq", dn_req, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tmo_o, 0);
    @(posedge clk); #1 rst_ni = 1;
    // Both ports stream reads, flash answers in one cycle.
    @(negedge clk);
    g0 = gnt_log.size(); run = 0;
    for (int i = 0; i < 4; i++) begin
      push_job(0, 0, 32'h4000_1000 + i * 4, 1'(i));
      push_job(1, 0, 32'h4000_2000 + i * 4, ~1'(i));
    end
    run = 1;
    wait_idle();
    check("alt_count", gnt_log.size() - g0, 8);
    for (int i = 0; i < 8; i++) check("alt_gnt", log_at(g0 + i), (i % 2 == 0) ? 2'b01 : 2'b10);
    // Single read, three-cycle flash latency.
    rsp_lat = 3; g0 = gnt_log.size();
    push_job(0, 0, 32'h4000_0010, 1);
    wait_idle();
    check("t1_gnt", log_at(g0), 2'b01);
    check("t1_lat", rv_cyc - gnt_cyc, 3);
    check("t1_rdata", last_rdata, 32'h1234_5678);
    check("t1_err", last_err, 0);
    check("t1_tmo", tmo_cnt, 0);
    // Local errors and window edges.
    rsp_lat = 1; g0 = gnt_log.size();
    push_job(1, 1, 32'h4000_0000, 0);
    wait_idle();
    check("t3_wr_lat", rv_cyc - gnt_cyc, 1);
    push_job(0, 0, 32'h3FFF_FFFC, 1);
    wait_idle();
    check("t3_lo_lat", rv_cyc - gnt_cyc, 1);
    push_job(0, 0, 32'h4100_0000, 0);
    wait_idle();
    push_job(1, 0, 32'h40FF_FFFC, 1);
    wait_idle();
    check("t3_wr_dnreq", dn_at(g0), 0);
    check("t3_lo_dnreq", dn_at(g0 + 1), 0);
    check("t3_hi_dnreq", dn_at(g0 + 2), 0);
    check("t3_top_dnreq", dn_at(g0 + 3), 1);
    check("t3_top_err", last_err, 0);
    // Flash stalls the grant while port1 joins in.
    rsp_lat = 2; gnt_en = 0; g0 = gnt_log.size();
    push_job(0, 0, 32'h4000_0100, 0);
    repeat (2) @(posedge clk);
    push_job(1, 0, 32'h4000_0200, 1);
    repeat (5) begin
      @(negedge clk);
      check("t4_dn_addr", dn_addr, 32'h4000_0100);
      check("t4_dn_req", dn_req, 1);
      check("t4_no_gnt", up_gnt, 0);
    end
    @(posedge clk); #1 gnt_en = 1;
    wait_idle();
    check("t4_first", log_at(g0), 2'b01);
    check("t4_second", log_at(g0 + 1), 2'b10);
    check("t4_order", gnt_cyc_p[1] > rv_cyc_p[0], 1);
    // Timeout, drained late response, then a normal read.
    mute = 1; rsp_lat = 1; rv0 = rv_total;
    push_job(0, 0, 32'h4000_4000, 1, 1);
    n = 0;
    while (rv_total == rv0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_rv_seen", rv_total > rv0, 1);
    check("t5_lat", rv_cyc - gnt_cyc, 8);
    check("t5_tmo", tmo_cnt, 1);
    rv1 = rv_total;
    repeat (20) @(negedge clk);
    check("t5_drain_busy", busy, 1);
    check("t5_no_rv_wait", rv_total, rv1);
    late_req++;
    repeat (3) @(negedge clk);
    check("t5_dropped", rv_total, rv1);
    check("t5_idle", busy, 0);
    check("t5_tmo_once", tmo_cnt, 1);
    mute = 0;
    push_job(0, 0, 32'h4000_4004, 0);
    wait_idle();
    check("t5_next_err", last_err, 0);
    check("t5_next_rdata", last_rdata, 32'h4000_4004 ^ K);
    // Reset during WAIT_RSP.
    mute = 1; g0 = gnt_log.size();
    push_job(0, 0, 32'h4000_3000, 0);
    n = 0;
    while (gnt_log.size() == g0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_gnt", log_at(g0), 2'b01);
    @(posedge clk); #1 rst_ni = 0;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    @(posedge clk); #1 rst_ni = 1;
    @(negedge clk);
    check("t6_gnt0", up_gnt, 0);
    check("t6_rvalid0", up_rvalid, 0);
    check("t6_rdata0", up_rdata, 0);
    check("t6_dnreq0", dn_req, 0);
    check("t6_busy0", busy, 0);
    check("t6_tmo0", tmo_o, 0);
    exp_q[0].delete();
    mute = 0; run = 0; g1 = gnt_log.size();
    push_job(0, 0, 32'h4000_5000, 0);
    push_job(1, 0, 32'h4000_6000, 1);
    run = 1;
    wait_idle();
    check("t6_rr_ptr", log_at(g1), 2'b01);
    check("t6_rr_next", log_at(g1 + 1), 2'b10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
